// File: rtl/smc_rdata_lite23_pkg.sv
// smc_rdata_lite23_pkg: size codes, FSM encoding and access-count decode shared
// with the address generator.
package smc_rdata_lite23_pkg;

    localparam logic [1:0] XSIZ_8  = 2'b00;
    localparam logic [1:0] XSIZ_16 = 2'b01;
    localparam logic [1:0] XSIZ_32 = 2'b10;
    localparam logic [1:0] BSIZ_8  = 2'b00;
    localparam logic [1:0] BSIZ_16 = 2'b01;
    localparam logic [1:0] BSIZ_32 = 2'b10;

    typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} state_t;

    // Number of external accesses minus one; code 2'b11 behaves as 32-bit.
    function automatic logic [1:0] acc_cnt_m1(input logic [1:0] xfer_size, input logic [1:0] bus_size);
        logic x32;
        x32 = xfer_size[1];
        return (x32 && bus_size == BSIZ_8) ? 2'd3 :
               ((x32 && bus_size == BSIZ_16) || (xfer_size == XSIZ_16 && bus_size == BSIZ_8)) ? 2'd1 : 2'd0;
    endfunction

endpackage

// File: rtl/smc_rdata_fmt_lite23.sv
// smc_rdata_fmt_lite23: lane select and replication of the assembled read value
// into an AHB-lane-formatted word.
module smc_rdata_fmt_lite23
    import smc_rdata_lite23_pkg::*;
(
    input  logic [31:0] v,
    input  logic [31:0] data,
    input  logic [1:0]  xfer_size,
    input  logic [1:0]  bus_size,
    input  logic [1:0]  addr,
    output logic [31:0] word
);
    logic        is8;
    logic        is16;
    logic [15:0] h;
    logic [7:0]  b;
    logic [7:0]  b32;

    always_comb begin
        is8  = bus_size == BSIZ_8;
        is16 = bus_size == BSIZ_16;
        b32  = addr[1] ? (addr[0] ? data[31:24] : data[23:16]) : (addr[0] ? data[15:8] : data[7:0]);
        // Wide buses return the whole word in one beat, so the lane comes straight from the bus.
        h    = (is8 || is16) ? v[15:0] : (addr[1] ? data[31:16] : data[15:0]);
        b    = is8 ? v[7:0] : is16 ? (addr[0] ? data[15:8] : data[7:0]) : b32;
        word = (xfer_size == XSIZ_8) ? {4{b}} : (xfer_size == XSIZ_16) ? {2{h}} : v;
    end

endmodule

// File: rtl/smc_rdata_lite23.sv
// smc_rdata_lite23: collects 1, 2 or 4 external read beats into one AHB read word
// with a single-cycle valid pulse.
module smc_rdata_lite23
    import smc_rdata_lite23_pkg::*;
(
    input  logic        sys_clk23,
    input  logic        n_sys_reset23,
    input  logic        valid_access23,
    input  logic        n_read23,
    input  logic [1:0]  v_xfer_size23,
    input  logic [1:0]  v_bus_size23,
    input  logic [1:0]  addr23,
    input  logic        smc_rd_stb23,
    input  logic [31:0] data_smc23,
    input  logic        abort23,
    output logic [31:0] read_data23,
    output logic        rdata_valid23,
    output logic        busy23,
    output logic [1:0]  acc_left23
);
    state_t      state;
    logic [1:0]  xfer_q;
    logic [1:0]  bus_q;
    logic [1:0]  addr_q;
    logic [23:0] acc;
    logic [31:0] acc_nxt;
    logic [31:0] fmt;

    // Earlier beats shift up, so the first beat lands in the most-significant lane.
    always_comb
        acc_nxt = (bus_q == BSIZ_8)  ? {acc[23:0], data_smc23[7:0]} :
                  (bus_q == BSIZ_16) ? {acc[15:0], data_smc23[15:0]} : data_smc23;

    smc_rdata_fmt_lite23 u_fmt (
        .v         (acc_nxt),
        .data      (data_smc23),
        .xfer_size (xfer_q),
        .bus_size  (bus_q),
        .addr      (addr_q),
        .word      (fmt)
    );

    assign busy23 = state == COLLECT;

    always_ff @(posedge sys_clk23 or negedge n_sys_reset23) begin
        if (!n_sys_reset23) begin
            state         <= IDLE;
            xfer_q        <= XSIZ_8;
            bus_q         <= BSIZ_8;
            addr_q        <= 2'd0;
            acc           <= 24'd0;
            acc_left23    <= 2'd0;
            read_data23   <= 32'd0;
            rdata_valid23 <= 1'b0;
        end else begin
            rdata_valid23 <= 1'b0;
            if (abort23) begin
                state      <= IDLE;
                acc_left23 <= 2'd0;
            end else if (valid_access23 && (n_read23 || state == COLLECT)) begin
                // A new access during COLLECT discards the partial word.
                state      <= n_read23 ? COLLECT : IDLE;
                acc_left23 <= n_read23 ? acc_cnt_m1(v_xfer_size23, v_bus_size23) : 2'd0;
                xfer_q     <= v_xfer_size23;
                bus_q      <= v_bus_size23;
                addr_q     <= addr23;
                acc        <= 24'd0;
            end else if (state == COLLECT && smc_rd_stb23) begin
                acc <= acc_nxt[23:0];
                if (acc_left23 == 2'd0) begin
                    read_data23   <= fmt;
                    rdata_valid23 <= 1'b1;
                    state         <= IDLE;
                end else begin
                    acc_left23 <= acc_left23 - 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_smc_rdata_lite23.sv
// tb_smc_rdata_lite23: directed vectors with hand-computed expectations for the
// read-data assembler.
module tb_smc_rdata_lite23;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_access = 1'b0;
    logic        n_read = 1'b1;
    logic [1:0]  xfer_size = 2'b00;
    logic [1:0]  bus_size = 2'b00;
    logic [1:0]  addr = 2'b00;
    logic        stb = 1'b0;
    logic [31:0] data = 32'd0;
    logic        abort = 1'b0;
    logic [31:0] read_data;
    logic        rdata_valid;
    logic        busy;
    logic [1:0]  acc_left;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    smc_rdata_lite23 dut (
        .sys_clk23      (clk),
        .n_sys_reset23  (rst_n),
        .valid_access23 (valid_access),
        .n_read23       (n_read),
        .v_xfer_size23  (xfer_size),
        .v_bus_size23   (bus_size),
        .addr23         (addr),
        .smc_rd_stb23   (stb),
        .data_smc23     (data),
        .abort23        (abort),
        .read_data23    (read_data),
        .rdata_valid23  (rdata_valid),
        .busy23         (busy),
        .acc_left23     (acc_left)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [1:0] xs, input logic [1:0] bs, input logic [1:0] a);
        valid_access = 1'b1; n_read = 1'b1; xfer_size = xs; bus_size = bs; addr = a;
        tick();
        valid_access = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d);
        stb = 1'b1; data = d;
        tick();
        stb = 1'b0;
    endtask

    initial begin
        tick(); tick();
        chk("rst_read_data", read_data, 32'h0);
        chk("rst_valid", {31'd0, rdata_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_acc_left", {30'd0, acc_left}, 32'd0);
        rst_n = 1'b1;
        tick();

        // xfer32 on bus8
        start(2'b10, 2'b00, 2'b00);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_left3", {30'd0, acc_left}, 32'd3);
        beat(32'hAA);
        chk("t1_left2", {30'd0, acc_left}, 32'd2);
        chk("t1_novalid", {31'd0, rdata_valid}, 32'd0);
        beat(32'hBB);
        chk("t1_left1", {30'd0, acc_left}, 32'd1);
        beat(32'hCC);
        chk("t1_left0", {30'd0, acc_left}, 32'd0);
        chk("t1_busy_pre", {31'd0, busy}, 32'd1);
        beat(32'hDD);
        chk("t1_valid", {31'd0, rdata_valid}, 32'd1);
        chk("t1_data", read_data, 32'hAABBCCDD);
        chk("t1_busy_done", {31'd0, busy}, 32'd0);

        // back-to-back: xfer16 on bus8 accepted in the pulse cycle
        start(2'b01, 2'b00, 2'b10);
        chk("t2_pulse_one_cycle", {31'd0, rdata_valid}, 32'd0);
        chk("t2_busy", {31'd0, busy}, 32'd1);
        chk("t2_left1", {30'd0, acc_left}, 32'd1);
        beat(32'h12);
        chk("t2_busy_mid", {31'd0, busy}, 32'd1);
        beat(32'h34);
        chk("t2_busy_done", {31'd0, busy}, 32'd0);
        chk("t2_valid", {31'd0, rdata_valid}, 32'd1);
        chk("t2_data", read_data, 32'h12341234);

        // xfer8 on bus32; strobe with valid_access in IDLE is ignored
        stb = 1'b1; data = 32'h11111111;
        start(2'b00, 2'b10, 2'b10);
        stb = 1'b0;
        chk("t3_idle_stb_valid", {31'd0, rdata_valid}, 32'd0);
        chk("t3_busy", {31'd0, busy}, 32'd1);
        beat(32'h00C30000);
        chk("t3_valid", {31'd0, rdata_valid}, 32'd1);
        chk("t3_data", read_data, 32'hC3C3C3C3);

        // xfer32 on bus16 with abort after first beat
        start(2'b10, 2'b01, 2'b00);
        chk("t4_left1", {30'd0, acc_left}, 32'd1);
        beat(32'h5566);
        chk("t4_left0", {30'd0, acc_left}, 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_abort_busy", {31'd0, busy}, 32'd0);
        chk("t4_abort_valid", {31'd0, rdata_valid}, 32'd0);
        chk("t4_abort_data", read_data, 32'hC3C3C3C3);
        chk("t4_abort_left", {30'd0, acc_left}, 32'd0);
        start(2'b10, 2'b01, 2'b00);
        beat(32'h1122);
        beat(32'h3344);
        chk("t4_valid", {31'd0, rdata_valid}, 32'd1);
        chk("t4_data", read_data, 32'h11223344);

        // restart after 2 beats; restart beats outrank a concurrent strobe
        start(2'b10, 2'b00, 2'b00);
        beat(32'h01);
        beat(32'h02);
        stb = 1'b1; data = 32'h99;
        start(2'b10, 2'b00, 2'b00);
        stb = 1'b0;
        chk("t5_restart_left", {30'd0, acc_left}, 32'd3);
        chk("t5_restart_valid", {31'd0, rdata_valid}, 32'd0);
        beat(32'h10);
        beat(32'h20);
        beat(32'h30);
        beat(32'h40);
        chk("t5_valid", {31'd0, rdata_valid}, 32'd1);
        chk("t5_data", read_data, 32'h10203040);

        // remaining lane-select cases
        start(2'b00, 2'b01, 2'b01);
        beat(32'hFFFFAB12);
        chk("x8b16_data", read_data, 32'hABABABAB);
        start(2'b01, 2'b10, 2'b10);
        beat(32'h5A5BCCDD);
        chk("x16b32_data", read_data, 32'h5A5B5A5B);
        start(2'b00, 2'b00, 2'b11);
        beat(32'h0000007E);
        chk("x8b8_data", read_data, 32'h7E7E7E7E);
        start(2'b11, 2'b11, 2'b01);
        chk("inv_left", {30'd0, acc_left}, 32'd0);
        beat(32'hDEADBEEF);
        chk("inv_data", read_data, 32'hDEADBEEF);

        // strobes in IDLE and write accesses
        stb = 1'b1; data = 32'hFFFFFFFF;
        tick(); tick();
        stb = 1'b0;
        chk("t6_idle_valid", {31'd0, rdata_valid}, 32'd0);
        chk("t6_idle_data", read_data, 32'hDEADBEEF);
        valid_access = 1'b1; n_read = 1'b0; xfer_size = 2'b10; bus_size = 2'b00;
        tick();
        valid_access = 1'b0; n_read = 1'b1;
        chk("t6_write_busy", {31'd0, busy}, 32'd0);
        beat(32'h55);
        chk("t6_write_valid", {31'd0, rdata_valid}, 32'd0);

        // reset mid-COLLECT
        start(2'b10, 2'b00, 2'b00);
        beat(32'h77);
        stb = 1'b1; data = 32'h88;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_data", read_data, 32'h0);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_left", {30'd0, acc_left}, 32'd0);
        chk("t6_rst_valid", {31'd0, rdata_valid}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick(); tick();
        stb = 1'b0;
        chk("t6_post_valid", {31'd0, rdata_valid}, 32'd0);
        chk("t6_post_busy", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
